uart_cmd_decoder: RTL
=====================

Name: uart_cmd_decoder

Overview:
- Command-decoding controller that sits directly downstream of the UART receiver in system_top.
- Consumes received bytes and parses the 4 host command types (RF write, RF read, ALU op with operands, ALU op without operands).
- Drives register-file and ALU strobes.
- Pushes response bytes (RF read data, ALU result) into the TX-side FIFO.

Parameters:
- WIDTH, 8, data byte / RF word width
- ADDR_W, 4, register-file address width
- FUN_W, 4, ALU function code width
- TIMEOUT_CYCLES, 1024, inter-byte timeout in i_clk cycles (used only with the optional feature)

Ports:
- i_clk  in  1  system (reference) clock
- i_rst  in  1  asynchronous, active-low reset
- i_rx_data  in  WIDTH  received byte, already in i_clk domain
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_rf_addr  out  ADDR_W  RF address
- o_rf_wdata  out  WIDTH  RF write data
- o_rf_wr_en  out  1  one-cycle RF write strobe
- o_rf_rd_en  out  1  one-cycle RF read strobe
- i_rf_rd_data  in  WIDTH  RF read data
- i_rf_rd_valid  in  1  RF read data valid strobe
- o_alu_func  out  FUN_W  ALU function code
- o_alu_en  out  1  one-cycle ALU start strobe
- i_alu_out  in  2*WIDTH  ALU result
- i_alu_valid  in  1  ALU result valid strobe
- o_tx_data  out  WIDTH  byte to TX FIFO
- o_tx_wr_en  out  1  TX FIFO write strobe
- i_tx_full  in  1  TX FIFO full
- o_busy  out  1  high whenever state != IDLE
- o_drop  out  1  one-cycle pulse: received byte discarded

Behaviour:
- Reset (i_rst low, async): state IDLE; all outputs 0; captured result register 0.
- All outputs are registered. A strobe appears the cycle after the i_rx_valid / i_*_valid edge that causes it.
- Command opcodes: 0xAA RF_WR, 0xBB RF_RD, 0xCC ALU_OP, 0xDD ALU_NOP.
- IDLE:
  - byte 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> OPA
  - 0xDD -> ALU_FUN
  - any other byte -> stay IDLE, pulse o_drop
- WR_ADDR: byte[ADDR_W-1:0] latched to o_rf_addr -> WR_DATA.
- WR_DATA: byte -> o_rf_wdata; o_rf_wr_en pulses 1 cycle -> IDLE.
- RD_ADDR: byte -> o_rf_addr; o_rf_rd_en pulses 1 cycle -> RD_WAIT.
- RD_WAIT: on i_rf_rd_valid, capture i_rf_rd_data -> TX_LO (single byte, then IDLE).
- OPA: byte written to RF address 0 (o_rf_addr=0, o_rf_wdata=byte, o_rf_wr_en pulse) -> OPB.
- OPB: byte written to RF address 1, same rule -> ALU_FUN.
- ALU_FUN: o_alu_func=byte[FUN_W-1:0]; o_alu_en pulses 1 cycle -> ALU_WAIT.
- ALU_WAIT: on i_alu_valid, capture i_alu_out -> TX_LO, then TX_HI.
- TX_LO / TX_HI:
  - o_tx_wr_en=1 with the byte only in a cycle where i_tx_full=0; otherwise hold state, no write.
  - Low byte first, then high byte (ALU only).
  - After the last byte -> IDLE.
- Bytes arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: ignored, o_drop pulses; state unaffected.
- Simultaneous i_rx_valid and i_*_valid in a wait state: result captured, byte dropped.
- Upper unused bits of address/func bytes are ignored.
- o_busy is combinational from state, 0 only in IDLE.
- Reset mid-command: immediate return to IDLE; any pending strobe is lost, no partial write.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined:
  - a counter restarts on every accepted byte while in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB or ALU_FUN;
  - reaching TIMEOUT_CYCLES without a byte -> IDLE, o_drop pulses once, no RF/ALU strobe issued.
- Not defined: no counter logic; those states wait indefinitely.

Test Plan:
- Reset then bytes AA,05,3C -> one o_rf_wr_en pulse, addr=5, wdata=0x3C, 1 cycle after the 0x3C strobe; o_busy back to 0.
- BB,05 -> o_rf_rd_en pulse at addr 5; drive i_rf_rd_data=0x3C with valid -> single o_tx_wr_en with 0x3C.
- CC,0A,14,00 -> RF writes (0,0x0A) then (1,0x14), then o_alu_en with func=0; i_alu_out=0x001E -> TX bytes 0x1E then 0x00.
- DD,02 with i_tx_full held high 5 cycles after i_alu_valid (result 0x1234) -> no write while full; then 0x34 then 0x12.
- Byte 0x7F in IDLE, and a byte during ALU_WAIT -> o_drop pulses, no strobes, state unchanged.
- With CMD_TIMEOUT_EN: AA,05 then silence for TIMEOUT_CYCLES -> IDLE, o_drop, no write. Also: reset asserted mid WR_DATA -> all outputs 0 at once.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Parses host command bytes from the UART RX path and drives the
//            register-file and ALU strobes; returns result bytes to the TX FIFO.
//            Optional inter-byte timeout: define CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder #(
    parameter int WIDTH          = 8,
    parameter int ADDR_W         = 4,
    parameter int FUN_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH-1:0]     i_rx_data,
    input  logic                 i_rx_valid,
    output logic [ADDR_W-1:0]    o_rf_addr,
    output logic [WIDTH-1:0]     o_rf_wdata,
    output logic                 o_rf_wr_en,
    output logic                 o_rf_rd_en,
    input  logic [WIDTH-1:0]     i_rf_rd_data,
    input  logic                 i_rf_rd_valid,
    output logic [FUN_W-1:0]     o_alu_func,
    output logic                 o_alu_en,
    input  logic [2*WIDTH-1:0]   i_alu_out,
    input  logic                 i_alu_valid,
    output logic [WIDTH-1:0]     o_tx_data,
    output logic                 o_tx_wr_en,
    input  logic                 i_tx_full,
    output logic                 o_busy,
    output logic                 o_drop
);

    localparam logic [WIDTH-1:0] c_OP_RF_WR   = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] c_OP_RF_RD   = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] c_OP_ALU_OP  = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0] c_OP_ALU_NOP = WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_OPA      = 4'd5,
        S_OPB      = 4'd6,
        S_ALU_FUN  = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_TX_LO    = 4'd9,
        S_TX_HI    = 4'd10
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_two_bytes;

    // A zero-length timeout would make every collecting state exit immediately.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_chk
        $error("uart_cmd_decoder: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef CMD_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_collecting;

    assign w_collecting = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) ||
                          (r_state == S_RD_ADDR) || (r_state == S_OPA)     ||
                          (r_state == S_OPB)     || (r_state == S_ALU_FUN);
`endif

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_two_bytes <= 1'b0;
            o_rf_addr   <= '0;
            o_rf_wdata  <= '0;
            o_rf_wr_en  <= 1'b0;
            o_rf_rd_en  <= 1'b0;
            o_alu_func  <= '0;
            o_alu_en    <= 1'b0;
            o_tx_data   <= '0;
            o_tx_wr_en  <= 1'b0;
            o_drop      <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            o_rf_wr_en <= 1'b0;
            o_rf_rd_en <= 1'b0;
            o_alu_en   <= 1'b0;
            o_tx_wr_en <= 1'b0;
            o_drop     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            c_OP_RF_WR:   r_state <= S_WR_ADDR;
                            c_OP_RF_RD:   r_state <= S_RD_ADDR;
                            c_OP_ALU_OP:  r_state <= S_OPA;
                            c_OP_ALU_NOP: r_state <= S_ALU_FUN;
                            default:      o_drop  <= 1'b1;
                        endcase
                    end
                end

                S_WR_ADDR: begin
                    if (i_rx_valid) begin
                        o_rf_addr <= i_rx_data[ADDR_W-1:0];
                        r_state   <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (i_rx_valid) begin
                        o_rf_wdata <= i_rx_data;
                        o_rf_wr_en <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (i_rx_valid) begin
                        o_rf_addr  <= i_rx_data[ADDR_W-1:0];
                        o_rf_rd_en <= 1'b1;
                        r_state    <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (i_rf_rd_valid) begin
                        r_result    <= {{WIDTH{1'b0}}, i_rf_rd_data};
                        r_two_bytes <= 1'b0;
                        r_state     <= S_TX_LO;
                    end
                    if (i_rx_valid) begin
                        o_drop <= 1'b1;
                    end
                end

                // Operands are staged through RF locations 0 and 1.
                S_OPA: begin
                    if (i_rx_valid) begin
                        o_rf_addr  <= '0;
                        o_rf_wdata <= i_rx_data;
                        o_rf_wr_en <= 1'b1;
                        r_state    <= S_OPB;
                    end
                end

                S_OPB: begin
                    if (i_rx_valid) begin
                        o_rf_addr  <= ADDR_W'(1);
                        o_rf_wdata <= i_rx_data;
                        o_rf_wr_en <= 1'b1;
                        r_state    <= S_ALU_FUN;
                    end
                end

                S_ALU_FUN: begin
                    if (i_rx_valid) begin
                        o_alu_func <= i_rx_data[FUN_W-1:0];
                        o_alu_en   <= 1'b1;
                        r_state    <= S_ALU_WAIT;
                    end
                end

                S_ALU_WAIT: begin
                    if (i_alu_valid) begin
                        r_result    <= i_alu_out;
                        r_two_bytes <= 1'b1;
                        r_state     <= S_TX_LO;
                    end
                    if (i_rx_valid) begin
                        o_drop <= 1'b1;
                    end
                end

                S_TX_LO: begin
                    if (!i_tx_full) begin
                        o_tx_data  <= r_result[WIDTH-1:0];
                        o_tx_wr_en <= 1'b1;
                        r_state    <= r_two_bytes ? S_TX_HI : S_IDLE;
                    end
                    if (i_rx_valid) begin
                        o_drop <= 1'b1;
                    end
                end

                S_TX_HI: begin
                    if (!i_tx_full) begin
                        o_tx_data  <= r_result[2*WIDTH-1:WIDTH];
                        o_tx_wr_en <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                    if (i_rx_valid) begin
                        o_drop <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase

`ifdef CMD_TIMEOUT_EN
            // Overrides the case above: a silent collecting state is abandoned.
            if (w_collecting && !i_rx_valid) begin
                if (r_tmo_cnt == c_TMO_LAST) begin
                    r_state   <= S_IDLE;
                    o_drop    <= 1'b1;
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end else begin
                r_tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule

`default_nettype wire
